logic_gate_sweep: RTL

//  Parametrised N-input logic gate with a registered output and a built-in

---
 rtl/logic_gate_sweep.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/logic_gate_sweep.sv
// logic_gate_sweep: N_IN-input run-time selectable logic gate with a registered
// output and an on-chip exhaustive truth-table sweeper that counts the number
// of operand patterns producing a '1'.
//
// Optional feature macro: LGS_PAUSE_EN
//   defined   -> extra 'pause' input freezes a running sweep
//   undefined -> no pause port, sweeps run uninterrupted
//
// Gate functions (mode):
//   0 AND  1 OR  2 XOR  3 NAND  4 NOR  5 XNOR  6 MAJ  7 reserved (0)

// Combinational gate evaluator shared by the live path and the sweep path.
module lgs_gate_eval #(
  parameter int N_IN = 3
) (
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] v,
  output logic            f
);

  logic [3:0] pop;
  logic       maj;

  // Population count of the operand vector (N_IN <= 8 fits in 4 bits).
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IN; i++) pop = pop + {3'b000, v[i]};
  end

  // Majority is a strict majority: popcount above N_IN/2 (integer division).
  assign maj = (pop > 4'(N_IN / 2));

  // Function select; reserved encoding yields a constant 0.
  always_comb begin
    f = 1'b0;
    case (mode)
      3'd0:    f = &v;
      3'd1:    f = |v;
      3'd2:    f = ^v;
      3'd3:    f = ~&v;
      3'd4:    f = ~|v;
      3'd5:    f = ~^v;
      3'd6:    f = maj;
      default: f = 1'b0;
    endcase
  end

endmodule

module logic_gate_sweep #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef LGS_PAUSE_EN
  input  logic            pause,
`endif
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] ext_in,
  output logic            y,
  output logic [N_IN-1:0] pattern,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt
);

  // Elaboration-time guard on the supported operand width.
  if (N_IN < 2 || N_IN > 8) begin : g_bad_n_in
    $error("logic_gate_sweep: N_IN must be in 2..8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [N_IN-1:0]   pattern_d;
  logic [N_IN:0]     ones_d;
  logic              y_d;
  logic              hold;

  logic [2:0]        eval_mode;
  logic [N_IN-1:0]   eval_v;
  logic              eval_f;

  localparam logic [N_IN-1:0] PAT_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] PAT_LAST = {N_IN{1'b1}};

`ifdef LGS_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Sweep evaluates the latched mode on the internal pattern; otherwise the
  // gate follows the live mode and external operands.
  always_comb begin
    eval_mode = mode;
    eval_v    = ext_in;
    if (state_q == SWEEP) begin
      eval_mode = mode_q;
      eval_v    = pattern;
    end
  end

  lgs_gate_eval #(.N_IN(N_IN)) u_eval (
    .mode (eval_mode),
    .v    (eval_v),
    .f    (eval_f)
  );

  // Next-state and datapath update; everything holds unless changed below.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern;
    ones_d    = ones_cnt;
    y_d       = y;
    case (state_q)
      IDLE: begin
        y_d = eval_f;
        if (start) begin
          mode_d    = mode;
          pattern_d = '0;
          ones_d    = '0;
          state_d   = SWEEP;
        end
      end
      SWEEP: begin
        // A paused sweep freezes y, the counter, the pattern and the state.
        if (!hold) begin
          y_d    = eval_f;
          ones_d = ones_cnt + {{N_IN{1'b0}}, eval_f};
          if (pattern == PAT_LAST) state_d = DONE;
          else                     pattern_d = pattern + PAT_ONE;
        end
      end
      DONE: begin
        // Single-cycle completion state; start is not looked at here.
        y_d     = eval_f;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sweep in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      pattern  <= '0;
      ones_cnt <= '0;
      y        <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pattern  <= pattern_d;
      ones_cnt <= ones_d;
      y        <= y_d;
    end
  end

  // Status flags decoded straight from the state register.
  assign busy = (state_q == SWEEP);
  assign done = (state_q == DONE);

endmodule
